// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer RAM arbiter: display scan-out reads vs pixel writer
module fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]            starve_cnt;
  logic                  force_wr;
  logic                  wr_win;
  logic                  disp_win;
  logic [RD_LATENCY-1:0] tag;
  logic [RD_LATENCY-1:0] tag_nxt;

  // Writer owns the RAM in blanking or once it has starved MAX_WAIT cycles.
  always_comb begin
    force_wr = !blank && wr_valid && (starve_cnt == MAX_WAIT_C);
    wr_win   = 1'b0;
    disp_win = 1'b0;
    if (!rst) begin
      if (blank || force_wr) begin
        wr_win   = wr_valid;
        disp_win = disp_req && !wr_valid;
      end else begin
        disp_win = disp_req;
        wr_win   = wr_valid && !disp_req;
      end
    end
  end

  assign disp_gnt = disp_win;
  assign wr_ready = wr_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!wr_valid || wr_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt < MAX_WAIT_C) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= wr_win | disp_win;
      mem_we <= wr_win;
      if (wr_win) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (disp_win) begin
        mem_addr <= disp_addr;
      end
    end
  end

  // The last tag stage is disp_rvalid itself; data is captured on the edge that sets it.
  always_comb begin
    tag_nxt    = '0;
    tag_nxt[0] = mem_en & ~mem_we;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_nxt[i] = tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag        <= '0;
      disp_rdata <= '0;
    end else begin
      tag <= tag_nxt;
      if (tag_nxt[RD_LATENCY-1]) begin
        disp_rdata <= mem_rdata;
      end
    end
  end

  assign disp_rvalid = tag[RD_LATENCY-1];

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter with a behavioural RAM macro
module tb_fb_arbiter;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 16;
  localparam int RD_LATENCY = 2;
  localparam int MAX_WAIT   = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              blank = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'(a * 40503) ^ 16'hA5C3;
  endfunction

  // RAM macro: one register stage on reads, so data lands RD_LATENCY-1 cycles after mem_en.
  logic [DATA_W-1:0] ram [int];
  logic [DATA_W-1:0] shadow [int];

  function automatic logic [DATA_W-1:0] ram_rd(input int a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] sh_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) ram[int'(mem_addr)] = mem_wdata;
    if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= ram_rd(int'(mem_addr));
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;

  rd_t sb[$];
  int  cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]        m_starve = '0;
  logic              armed = 1'b0;
  logic              exp_w, exp_d;
  logic              e_en, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata;
  rd_t               item;
  int                rv_cnt = 0;
  int                wr_cnt = 0;

  always @(negedge clk) begin
    exp_w = 1'b0;
    exp_d = 1'b0;
    if (!rst) begin
      if (wr_valid && (blank || !disp_req || m_starve == 8'(MAX_WAIT))) exp_w = 1'b1;
      else if (disp_req) exp_d = 1'b1;
    end
    check("disp_gnt", 32'(disp_gnt), 32'(exp_d));
    check("wr_ready", 32'(wr_ready), 32'(exp_w));
    check("mutex", 32'(disp_gnt & wr_ready), 32'd0);
    if (armed) begin
      check("mem_en", 32'(mem_en), 32'(e_en));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      if (disp_rvalid === 1'b1) begin
        rv_cnt++;
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          item = sb.pop_front();
          check("rd_cycle", 32'(cyc), 32'(item.due));
          check("rd_data", 32'(disp_rdata), 32'(item.data));
          e_rdata = item.data;
        end
      end else begin
        check("rvalid_low", 32'(disp_rvalid), 32'd0);
        check("rdata_hold", 32'(disp_rdata), 32'(e_rdata));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("rd_missing", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
    if (rst) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      m_starve = '0;
      sb.delete();
      armed = 1'b1;
    end else begin
      e_en = exp_w | exp_d;
      e_we = exp_w;
      if (exp_w) begin
        e_addr = wr_addr;
        e_wdata = wr_data;
        shadow[int'(wr_addr)] = wr_data;
        wr_cnt++;
      end else if (exp_d) begin
        e_addr = disp_addr;
        item.data = sh_rd(int'(disp_addr));
        item.due = cyc + 1 + RD_LATENCY;
        sb.push_back(item);
      end
      if (!wr_valid || exp_w) m_starve = '0;
      else if (m_starve < 8'(MAX_WAIT)) m_starve = m_starve + 8'd1;
    end
  end

  task automatic drive(input logic r, input logic b, input logic dr, input int da,
                       input logic wv, input int wa, input logic [DATA_W-1:0] wd);
    @(posedge clk);
    #1;
    rst = r; blank = b; disp_req = dr; disp_addr = ADDR_W'(da);
    wr_valid = wv; wr_addr = ADDR_W'(wa); wr_data = wd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, '0);
  endtask

  task automatic measure_write(input int wa, input logic [DATA_W-1:0] wd, output int waited);
    waited = -1;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32 + k, 1'b1, wa, wd);
      @(negedge clk);
      #1;
      if (wr_ready) begin
        check("forced_dgnt", 32'(disp_gnt), 32'd0);
        waited = k;
        break;
      end
    end
  endtask

  int   base, waited;
  logic dr, wv, last_dgnt, last_wrdy;
  int   da, wa;
  logic [DATA_W-1:0] wd;

  initial begin
    drive(1'b1, 1'b0, 1'b1, 5, 1'b1, 6, 16'h1234);
    drive(1'b1, 1'b0, 1'b1, 5, 1'b1, 6, 16'h1234);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, '0);
    #3;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rvalid", 32'(disp_rvalid), 32'd0);
    check("rst_rdata", 32'(disp_rdata), 32'd0);

    base = rv_cnt;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, i, 1'b0, 0, '0);
    idle(6);
    check("reads_returned", 32'(rv_cnt - base), 32'd8);

    measure_write(32'h100, 16'hF800, waited);
    check("starve_wait_1", 32'(waited), 32'(MAX_WAIT));
    measure_write(32'h101, 16'h07E0, waited);
    check("starve_wait_2", 32'(waited), 32'(MAX_WAIT));
    idle(4);
    check("ram_0x100", 32'(ram_rd(32'h100)), 32'hF800);
    check("ram_0x101", 32'(ram_rd(32'h101)), 32'h07E0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h200 + i, 16'(i + 1));
      @(negedge clk);
      #1;
      check("blank_wr_ready", 32'(wr_ready), 32'd1);
      check("blank_dgnt", 32'(disp_gnt), 32'd0);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 0, '0);
    @(negedge clk);
    #1;
    check("blank_drop_wr", 32'(disp_gnt), 32'd1);
    idle(5);

    base = wr_cnt;
    for (int i = 0; i < 44; i++)
      drive(1'b0, 1'b0, 1'b1, i, (i % 11) != 10, 32'h300, 16'hBEEF);
    idle(5);
    check("idle_writer_no_grant", 32'(wr_cnt - base), 32'd0);

    base = rv_cnt;
    drive(1'b0, 1'b0, 1'b1, 3, 1'b0, 0, '0);
    drive(1'b0, 1'b0, 1'b1, 4, 1'b0, 0, '0);
    drive(1'b1, 1'b0, 1'b1, 4, 1'b1, 9, 16'h5555);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, '0);
      @(negedge clk);
      #1;
      check("post_rst_rvalid", 32'(disp_rvalid), 32'd0);
      check("post_rst_rdata", 32'(disp_rdata), 32'd0);
    end
    check("rst_dropped_reads", 32'(rv_cnt - base), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 5, 1'b0, 0, '0);
    idle(5);
    check("resume_read", 32'(rv_cnt - base), 32'd1);

    dr = 1'b0; wv = 1'b0; da = 0; wa = 0; wd = '0;
    last_dgnt = 1'b0; last_wrdy = 1'b0;
    base = rv_cnt;
    for (int i = 0; i < 10000; i++) begin
      if (!dr || last_dgnt) begin
        dr = ($urandom_range(0, 3) != 0);
        da = int'($urandom_range(0, 15));
      end
      if (!wv || last_wrdy) begin
        wv = ($urandom_range(0, 2) != 0);
        wa = int'($urandom_range(0, 15));
        wd = 16'($urandom);
      end
      drive(1'b0, $urandom_range(0, 3) == 0, dr, da, wv, wa, wd);
      @(negedge clk);
      #1;
      last_dgnt = disp_gnt;
      last_wrdy = wr_ready;
    end
    idle(6);
    check("sb_drained", 32'(sb.size()), 32'd0);
    for (int a = 0; a < 16; a++) check("ram_vs_model", 32'(ram_rd(a)), 32'(sh_rd(a)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
